// File: rtl/sr_latch_capture_pkg.sv
// Shared types for the SR latch capture stage: qualification FSM state enum.
package sr_latch_capture_pkg;

    `include "sr_capture_defs.vh"

    typedef enum logic [1:0] {
        ST_LOW       = SR_ST_LOW,
        ST_PEND_HIGH = SR_ST_PEND_HIGH,
        ST_HIGH      = SR_ST_HIGH,
        ST_PEND_LOW  = SR_ST_PEND_LOW
    } state_e;

endpackage

// File: rtl/sr_capture_defs.vh
// State encoding and synchronizer reset values shared by the sr_latch_capture slice.
`ifndef SR_CAPTURE_DEFS_VH
`define SR_CAPTURE_DEFS_VH

localparam logic [1:0] SR_ST_LOW       = 2'd0;
localparam logic [1:0] SR_ST_PEND_HIGH = 2'd1;
localparam logic [1:0] SR_ST_HIGH      = 2'd2;
localparam logic [1:0] SR_ST_PEND_LOW  = 2'd3;

// The latch powers up reset: Q low, Qn high.
localparam logic SR_SQ_RST  = 1'b0;
localparam logic SR_SQN_RST = 1'b1;

`endif

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer with synchronous reset to a chosen value.
module sync_ff_chain #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {DEPTH{RST_VAL}};
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/sr_latch_capture.sv
// Synchronizes NAND SR latch outputs, qualifies level changes and emits rise/fall pulses.
// Optional q==qn detection is built when SR_CAPTURE_ILLEGAL_DETECT_EN is defined.
module sr_latch_capture #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic q_in,
    input  logic qn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy,
    output logic illegal
);

    import sr_latch_capture_pkg::*;

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    logic             sq;
    logic             samp_valid;
    logic             samp_val;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    sync_ff_chain #(.DEPTH(SYNC_STAGES), .RST_VAL(SR_SQ_RST)) u_sync_q (
        .clk   (clk),
        .reset (reset),
        .d_i   (q_in),
        .q_o   (sq)
    );

`ifdef SR_CAPTURE_ILLEGAL_DETECT_EN
    logic             sqn;
    logic [CNT_W-1:0] inv_cnt_q;
    logic [CNT_W-1:0] inv_cnt_d;

    sync_ff_chain #(.DEPTH(SYNC_STAGES), .RST_VAL(SR_SQN_RST)) u_sync_qn (
        .clk   (clk),
        .reset (reset),
        .d_i   (qn_in),
        .q_o   (sqn)
    );

    assign samp_valid = (sq != sqn);
    assign inv_cnt_d  = inv_cnt_q + CNT_W'(1);

    // Run length of consecutive q==qn samples; saturates at STABLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            inv_cnt_q <= '0;
            illegal   <= 1'b0;
        end else if (samp_valid) begin
            inv_cnt_q <= '0;
            illegal   <= 1'b0;
        end else if (inv_cnt_q != STABLE) begin
            inv_cnt_q <= inv_cnt_d;
            illegal   <= (inv_cnt_d == STABLE);
        end
    end
`else
    logic unused_qn;

    assign unused_qn  = qn_in;
    assign samp_valid = 1'b1;
    assign illegal    = 1'b0;
`endif

    assign samp_val = sq;
    assign cnt_d    = cnt_q + CNT_W'(1);

    // Invalid samples leave state and counter untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (samp_valid) begin
                case (state_q)
                    ST_LOW: begin
                        if (samp_val) begin
                            if (STABLE_CYCLES == 1) begin
                                state_q <= ST_HIGH;
                                level   <= 1'b1;
                                rise    <= 1'b1;
                            end else begin
                                state_q <= ST_PEND_HIGH;
                                cnt_q   <= CNT_W'(1);
                                busy    <= 1'b1;
                            end
                        end
                    end
                    ST_PEND_HIGH: begin
                        if (!samp_val) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                        end else if (cnt_d == STABLE) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                            level   <= 1'b1;
                            rise    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_HIGH: begin
                        if (!samp_val) begin
                            if (STABLE_CYCLES == 1) begin
                                state_q <= ST_LOW;
                                level   <= 1'b0;
                                fall    <= 1'b1;
                            end else begin
                                state_q <= ST_PEND_LOW;
                                cnt_q   <= CNT_W'(1);
                                busy    <= 1'b1;
                            end
                        end
                    end
                    ST_PEND_LOW: begin
                        if (samp_val) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                        end else if (cnt_d == STABLE) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                            level   <= 1'b0;
                            fall    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_capture.sv
// Scoreboard bench for sr_latch_capture: a behavioural model predicts the outputs after every edge.
// Honours SR_CAPTURE_ILLEGAL_DETECT_EN the same way the design does.
module tb_sr_latch_capture;

    localparam int unsigned SS = 2;
    localparam int unsigned SC = 4;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic busy;
        logic illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic q_in = 1'b0;
    logic qn_in = 1'b1;
    logic level, rise, fall, busy, illegal;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Model: delayed raw samples plus a run-length view of qualification.
    logic m_sq[SS];
    logic m_sqn[SS];
    int   m_level;
    int   m_run;
    int   m_inv;

    always #5 clk = ~clk;

    sr_latch_capture #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .q_in    (q_in),
        .qn_in   (qn_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy),
        .illegal (illegal)
    );

    function automatic exp_t model_step(logic rst, logic q, logic qn);
        exp_t e;
        logic sq;
        logic sqn;
        bit   v;
        e = '0;
        if (rst) begin
            for (int i = 0; i < SS; i++) begin
                m_sq[i]  = 1'b0;
                m_sqn[i] = 1'b1;
            end
            m_level = 0;
            m_run   = 0;
            m_inv   = 0;
        end else begin
            sq  = m_sq[SS-1];
            sqn = m_sqn[SS-1];
`ifdef SR_CAPTURE_ILLEGAL_DETECT_EN
            v = (sq != sqn);
`else
            v = 1'b1;
`endif
            if (v) begin
                m_inv = 0;
                if (int'(sq) != m_level) begin
                    m_run++;
                    if (m_run == SC) begin
                        m_level = int'(sq);
                        m_run   = 0;
                        if (sq) e.rise = 1'b1;
                        else    e.fall = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (m_inv < SC) begin
                m_inv++;
            end
            for (int i = SS - 1; i > 0; i--) begin
                m_sq[i]  = m_sq[i-1];
                m_sqn[i] = m_sqn[i-1];
            end
            m_sq[0]  = q;
            m_sqn[0] = qn;
        end
        e.level   = (m_level != 0);
        e.busy    = (m_run != 0);
        e.illegal = (m_inv == SC);
        return e;
    endfunction

    task automatic drive(logic r, logic q, logic qn);
        @(negedge clk);
        reset = r;
        q_in  = q;
        qn_in = qn;
        exp_q.push_back(model_step(r, q, qn));
    endtask

    task automatic hold(int n, logic q, logic qn);
        for (int i = 0; i < n; i++) drive(1'b0, q, qn);
    endtask

    // Monitor: compare after every edge that has a prediction queued.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{level: level, rise: rise, fall: fall, busy: busy, illegal: illegal};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs cycle %0d: got lvl/rise/fall/busy/ill=%b expected %b",
                             cyc, got, e);
                end
            end
        end
    end

    initial begin
        logic q;
        logic qn;
        int   len;
        // Reset, then idle latch state.
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        hold(20, 1'b0, 1'b1);
        // Clean step up, then down.
        hold(10, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1);
        // Short glitches from LOW and from HIGH.
        hold(3, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1);
        hold(10, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b1);
        hold(10, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1);
        // Reset while pending high with the counter at 3, input kept high.
        hold(5, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        hold(10, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1);
        // q==qn run long enough to flag, then valid again.
        hold(10, 1'b1, 1'b1);
        hold(6, 1'b0, 1'b1);
        // Invalid sample in the middle of pending high.
        hold(2, 1'b1, 1'b0);
        hold(1, 1'b1, 1'b1);
        hold(8, 1'b1, 1'b0);
        // qn toggling while q is steady.
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        hold(8, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        // Randomized runs with occasional q==qn and rare resets.
        for (int blk = 0; blk < 400; blk++) begin
            q   = 1'($urandom_range(0, 1));
            qn  = ($urandom_range(0, 4) == 0) ? q : ~q;
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 99) == 0) drive(1'b1, q, qn);
            hold(len, q, qn);
        end
        hold(10, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_capture.md
# sr_latch_capture

Synchronous capture stage directly downstream of the NAND SR latch, which produces asynchronous q/qn outputs. The block synchronizes both latch outputs into the `clk` domain and qualifies them with a stability counter. It then publishes a clean level plus single-cycle rise and fall event pulses to the UART control logic. It also detects a latch stuck in the illegal or transient q==qn condition.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth per input, legal range 2..4.
- `STABLE_CYCLES`, 4: consecutive valid, changed samples needed to accept a new level, legal range 1..255.
- `CNT_W`, 8: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `q_in`  in  1  latch Q output; asynchronous to `clk`.
- `qn_in`  in  1  latch Qn output; asynchronous to `clk`.
- `level`  out  1  qualified latch state.
- `rise`  out  1  one-cycle pulse when `level` changes 0->1.
- `fall`  out  1  one-cycle pulse when `level` changes 1->0.
- `busy`  out  1  high while in a pending state.
- `illegal`  out  1  high while the q==qn condition persists (see Configuration).

## Operation
- Each input passes through its own `SYNC_STAGES`-deep flop chain, giving synchronized samples `sq` and `sqn`.
- Sample validity:
  - A sample is valid when `sq != sqn`; its value is `sq`.
  - A sample is invalid when `sq == sqn`.
- The FSM has four states:
  - LOW: `level`=0. A valid sample of 1 sets the counter to 1 and moves to PEND_HIGH. If STABLE_CYCLES=1, the block instead goes directly to HIGH with a `rise` pulse.
  - PEND_HIGH: a valid 1 increments the counter. When the counter reaches STABLE_CYCLES, go to HIGH, assert `rise`, set `level`=1 and clear the counter. A valid 0 clears the counter and returns to LOW with no pulse.
  - HIGH and PEND_LOW: mirror images of LOW and PEND_HIGH, using `fall`.
  - An invalid sample holds both the state and the counter; it neither advances nor cancels qualification.
- `rise` and `fall` are never asserted in the same cycle. Each is high for exactly one cycle per accepted transition.
- The counter saturates and never wraps; it cannot exceed STABLE_CYCLES by construction.
- `illegal` logic:
  - A separate invalid-run counter increments on each invalid sample and saturates at STABLE_CYCLES.
  - `illegal` asserts when this counter reaches STABLE_CYCLES.
  - The counter and `illegal` both clear on the first valid sample.

## Timing
- Reset values:
  - Synchronizer flops: `sq`=0 and `sqn`=1, matching the latch's reset-state output.
  - State LOW, all counters 0.
  - `level`=0, `rise`=0, `fall`=0, `busy`=0, `illegal`=0.
- Latency: an input change that is stable before clock edge 1 is reflected in `level`, with its pulse, after edge SYNC_STAGES+STABLE_CYCLES. With default parameters this is 6 edges.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-pending discards the qualification with no pulse. Flops take their reset values on the first edge where `reset` is high.
- An input glitch shorter than STABLE_CYCLES sample periods produces no pulse; `level` is unchanged.
- A change back-to-back with an accepted transition begins new qualification from the following cycle.

## Configuration
- `SR_CAPTURE_ILLEGAL_DETECT_EN` defined:
  - Both inputs are synchronized.
  - Validity checking and the `illegal` output operate as described above.
- Not defined:
  - `qn_in` is ignored and its synchronizer is not built.
  - Every sample is valid with value `sq`.
  - The invalid-run counter is removed and `illegal` is tied to 0.
  - Latency is unchanged.

## Structure
- Shared include `sr_capture_defs.vh` holds:
  - The state encoding constants (LOW=2'd0, PEND_HIGH=2'd1, HIGH=2'd2, PEND_LOW=2'd3).
  - The reset values for the synchronizer outputs.
- Sub-module `sync_ff_chain`: parameterized-depth single-bit synchronizer with synchronous reset and a reset-value parameter. It is instantiated once per input.

## Test plan
- Reset, then hold q_in=0, qn_in=1 for 20 cycles -> `level`=0, no pulses, `illegal`=0.
- Defaults; step to q_in=1, qn_in=0 -> `rise` high only in the cycle after edge 6, `level`=1 thereafter, `busy` high from edge 3 through edge 5.
- Defaults; a 3-cycle q=1 glitch from the LOW state -> no `rise`, `level` stays 0, `busy` drops when the glitch ends.
- With the macro defined, hold q_in=qn_in=1 for 10 cycles -> `illegal` rises after edge 6 and clears 2 edges after a valid sample returns. Verify that an invalid sample in the middle of PEND_HIGH delays `rise` by exactly one cycle.
- Assert `reset` while in PEND_HIGH with the counter at 3 -> no `rise`, state returns to LOW. With q=1 still applied, `rise` occurs 6 edges after `reset` deasserts.
- Build without the macro; toggle qn_in arbitrarily while q_in is steady -> no effect on any output, `illegal` is constantly 0.
